// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: clocked data memory with byte/half/word access, byte-lane
// stores, sign/zero-extended loads, a req/ready handshake with a fixed number
// of wait states, and misalignment / out-of-range error reporting.
// Optional feature macro: DATAMEM_INIT_CLEAR_EN -- when defined, the memory is
// swept to zero one word per cycle after every reset before requests are taken.
module data_mem_ctrl #(
   parameter int DEPTH       = 512,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        unsigned_ld,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        busy,
   output logic        misalign_err,
   output logic        oob_err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef DATAMEM_INIT_CLEAR_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_RESP  = 2'd2,
      ST_CLEAR = 2'd3
   } state_t;
   localparam state_t RST_STATE = ST_CLEAR;
   localparam logic   RST_BUSY  = 1'b1;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;
   localparam state_t RST_STATE = ST_IDLE;
   localparam logic   RST_BUSY  = 1'b0;
`endif

   // Right-justify the selected byte/half of a word and extend it.
   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [1:0]  sz,
                                                input logic [1:0]  lane,
                                                input logic        uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (sz)
         2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
         2'b01:   r = uns ? {16'h0000, h}   : {{16{h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // Byte-lane enables for a store of the given size at the given lane.
   function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] lane);
      logic [3:0] m;
      case (sz)
         2'b00:   m = 4'b0001 << lane;
         2'b01:   m = lane[1] ? 4'b1100 : 4'b0011;
         2'b10:   m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   // Replicate store data so every enabled lane sees its byte.
   function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
      logic [31:0] r;
      case (sz)
         2'b00:   r = {4{d[7:0]}};
         2'b01:   r = {2{d[15:0]}};
         default: r = d;
      endcase
      return r;
   endfunction

   // Alignment check; the reserved size always counts as misaligned.
   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lane);
      logic m;
      case (sz)
         2'b00:   m = 1'b0;
         2'b01:   m = lane[0];
         2'b10:   m = (lane != 2'b00);
         default: m = 1'b1;
      endcase
      return m;
   endfunction

   logic [31:0]      mem_q [DEPTH];

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             we_q, we_d;
   logic [1:0]       size_q, size_d;
   logic             uns_q, uns_d;
   logic [1:0]       lane_q, lane_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             mis_q, mis_d;
   logic             oob_q, oob_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             mis_err_q, mis_err_d;
   logic             oob_err_q, oob_err_d;
`ifdef DATAMEM_INIT_CLEAR_EN
   logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
`endif

   logic             acc_we_s;
   logic [1:0]       acc_size_s;
   logic             acc_uns_s;
   logic [1:0]       acc_lane_s;
   logic [IDX_W-1:0] acc_idx_s;
   logic [31:0]      acc_wdata_s;
   logic             acc_mis_s;
   logic             acc_oob_s;
   logic             new_mis_s;
   logic             new_oob_s;
   logic             enter_resp_s;
   logic             mem_we_s;
   logic [3:0]       mem_be_s;
   logic [IDX_W-1:0] mem_idx_s;
   logic [31:0]      mem_wdata_s;
   logic [31:0]      rd_word_s;

   // Current access fields: live inputs while idle (zero-wait path), latched copy otherwise.
   always_comb begin
      new_mis_s = is_misaligned(size, addr[1:0]);
      new_oob_s = ~new_mis_s & ({2'b00, addr[31:2]} >= 32'(DEPTH));
      if (state_q == ST_IDLE) begin
         acc_we_s    = we;
         acc_size_s  = size;
         acc_uns_s   = unsigned_ld;
         acc_lane_s  = addr[1:0];
         acc_idx_s   = addr[IDX_W+1:2];
         acc_wdata_s = wdata;
         acc_mis_s   = new_mis_s;
         acc_oob_s   = new_oob_s;
      end else begin
         acc_we_s    = we_q;
         acc_size_s  = size_q;
         acc_uns_s   = uns_q;
         acc_lane_s  = lane_q;
         acc_idx_s   = idx_q;
         acc_wdata_s = wdata_q;
         acc_mis_s   = mis_q;
         acc_oob_s   = oob_q;
      end
      rd_word_s = mem_q[acc_idx_s];
   end

   // Next-state, handshake outputs and memory write port.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      we_d         = we_q;
      size_d       = size_q;
      uns_d        = uns_q;
      lane_d       = lane_q;
      idx_d        = idx_q;
      wdata_d      = wdata_q;
      mis_d        = mis_q;
      oob_d        = oob_q;
      rdata_d      = rdata_q;
      ready_d      = 1'b0;
      busy_d       = busy_q;
      mis_err_d    = 1'b0;
      oob_err_d    = 1'b0;
      enter_resp_s = 1'b0;
      mem_we_s     = 1'b0;
      mem_be_s     = 4'b0000;
      mem_idx_s    = acc_idx_s;
      mem_wdata_s  = lane_data(acc_size_s, acc_wdata_s);
`ifdef DATAMEM_INIT_CLEAR_EN
      clr_idx_d    = clr_idx_q;
`endif
      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (req) begin
               we_d    = we;
               size_d  = size;
               uns_d   = unsigned_ld;
               lane_d  = addr[1:0];
               idx_d   = addr[IDX_W+1:2];
               wdata_d = wdata;
               mis_d   = new_mis_s;
               oob_d   = new_oob_s;
               busy_d  = 1'b1;
               if (WAIT_STATES > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = 4'(WAIT_STATES - 1);
               end else begin
                  enter_resp_s = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               enter_resp_s = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
`ifdef DATAMEM_INIT_CLEAR_EN
         ST_CLEAR: begin
            mem_we_s    = 1'b1;
            mem_be_s    = 4'b1111;
            mem_idx_s   = clr_idx_q;
            mem_wdata_s = 32'h0000_0000;
            busy_d      = 1'b1;
            if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
               state_d   = ST_IDLE;
               busy_d    = 1'b0;
               clr_idx_d = '0;
            end else begin
               clr_idx_d = clr_idx_q + 1'b1;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // Memory is touched on the edge that enters RESP, and only for clean requests.
      if (enter_resp_s) begin
         state_d   = ST_RESP;
         ready_d   = 1'b1;
         busy_d    = 1'b1;
         mis_err_d = acc_mis_s;
         oob_err_d = acc_oob_s;
         if (acc_mis_s || acc_oob_s) begin
            if (!acc_we_s) begin
               rdata_d = 32'h0000_0000;
            end else begin
               rdata_d = rdata_q;
            end
         end else if (acc_we_s) begin
            mem_we_s = 1'b1;
            mem_be_s = lane_mask(acc_size_s, acc_lane_s);
         end else begin
            rdata_d = load_extract(rd_word_s, acc_size_s, acc_lane_s, acc_uns_s);
         end
      end else begin
         enter_resp_s = 1'b0;
      end
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RST_STATE;
         cnt_q     <= 4'd0;
         we_q      <= 1'b0;
         size_q    <= 2'b00;
         uns_q     <= 1'b0;
         lane_q    <= 2'b00;
         idx_q     <= '0;
         wdata_q   <= 32'h0000_0000;
         mis_q     <= 1'b0;
         oob_q     <= 1'b0;
         rdata_q   <= 32'h0000_0000;
         ready_q   <= 1'b0;
         busy_q    <= RST_BUSY;
         mis_err_q <= 1'b0;
         oob_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         size_q    <= size_d;
         uns_q     <= uns_d;
         lane_q    <= lane_d;
         idx_q     <= idx_d;
         wdata_q   <= wdata_d;
         mis_q     <= mis_d;
         oob_q     <= oob_d;
         rdata_q   <= rdata_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         mis_err_q <= mis_err_d;
         oob_err_q <= oob_err_d;
      end
   end

`ifdef DATAMEM_INIT_CLEAR_EN
   // Clear-sweep index; a reset always restarts the sweep at word 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         clr_idx_q <= '0;
      end else begin
         clr_idx_q <= clr_idx_d;
      end
   end
`endif

   // Byte-lane write port; reset blocks any write so an aborted store never lands.
   always_ff @(posedge clk) begin
      if (!rst && mem_we_s) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_be_s[i]) begin
               mem_q[mem_idx_s][8*i +: 8] <= mem_wdata_s[8*i +: 8];
            end
         end
      end
   end

   assign rdata        = rdata_q;
   assign ready        = ready_q;
   assign busy         = busy_q;
   assign misalign_err = mis_err_q;
   assign oob_err      = oob_err_q;

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised, clocked data memory for the single-cycle/multi-cycle datapath. It supports byte, halfword and word accesses with byte-lane writes and sign/zero-extended loads. A request/ready handshake, a configurable wait-state count and error flags for misaligned or out-of-range addresses make it usable by both the multi-cycle controller and a future cache front end. It is the successor to the flat 512-word data memory and sits between the ALU address output and the write-back mux.

## Interface
- DEPTH, 512, number of 32-bit words; word index is addr[31:2]
- WAIT_STATES, 1, extra cycles between acceptance and response (0..15)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  1  access request; sampled only while busy=0
- we  in  1  1=store, 0=load; sampled with req
- size  in  2  00=byte, 01=half, 10=word, 11=reserved
- unsigned_ld  in  1  1=zero-extend, 0=sign-extend byte/half loads
- addr  in  32  byte address
- wdata  in  32  store data; low 8/16/32 bits used per size
- rdata  out  32  load result; held until the next completed load
- ready  out  1  one-cycle completion pulse
- busy  out  1  high from the cycle after acceptance through the ready cycle
- misalign_err  out  1  valid with ready; half on odd address, word on addr[1:0]!=0, or size=11
- oob_err  out  1  valid with ready; addr[31:2] >= DEPTH

## Operation
- FSM states: IDLE, WAIT, RESP (and CLEAR, see Configuration).
- IDLE: when req=1, latch we, size, unsigned_ld, addr and wdata, then compute the errors.
  - Go to WAIT when WAIT_STATES>0; otherwise go to RESP.
- WAIT: a down-counter is loaded with WAIT_STATES-1. Go to RESP when it reaches 0.
- Memory operation happens on the edge that enters RESP, and only if no error is set:
  - Store: little-endian byte lanes. Byte writes lane addr[1:0]; half writes lanes {addr[1],0} and {addr[1],1}; word writes all 4 lanes. Other lanes are unchanged.
  - Load: the selected byte/half is right-justified, then extended per unsigned_ld. Word loads are returned as-is.
- RESP: ready=1 and busy=1 for exactly one cycle, then the FSM returns to IDLE.
- Error requests:
  - Follow the same timing as a good request and flag the error with ready.
  - Memory is not modified.
  - A load error drives rdata=0.
  - misalign_err has priority; oob_err is evaluated only if aligned.
- A req asserted while busy=1 is ignored and not queued. The master holds it until busy=0.
- Reset values: state IDLE, rdata=0, ready=0, busy=0, misalign_err=0, oob_err=0, counter=0.
- Reset mid-operation (in WAIT or RESP) aborts the access: no write is committed and no ready pulse is issued.

## Timing
- Request accepted at edge N gives ready high during cycle N+1+WAIT_STATES.
- Back-to-back throughput is one access per WAIT_STATES+2 cycles.
- The earliest next acceptance is the edge after the ready cycle.
- rdata, misalign_err and oob_err become valid in the ready cycle:
  - rdata holds until the next completed load.
  - The error flags clear the cycle after ready.
- A load to the address of the immediately preceding store returns the new data; no hazard is exposed.
- Outputs are registered; there is no combinational path from any input to any output.

## Configuration
- Macro DATAMEM_INIT_CLEAR_EN:
  - Defined:
    - After rst deasserts, the FSM enters CLEAR and writes 0 to one word per cycle, indices 0..DEPTH-1, over DEPTH cycles.
    - busy=1 throughout; req is ignored.
    - The FSM enters IDLE after the last word.
    - rst during CLEAR restarts the sweep at index 0.
  - Undefined:
    - No CLEAR state; IDLE is entered directly after reset.
    - Memory contents are not initialised and are unchanged by rst.

## Test plan
- WAIT_STATES=1, word store 0xDEADBEEF to addr 0x10, then word load 0x10 -> ready two cycles after each acceptance, rdata=0xDEADBEEF, busy high for 2 cycles per access.
- Byte store 0x80 to addr 0x21 over word 0x00000000:
  - word load 0x20 -> 0x00008000.
  - lb 0x21 with unsigned_ld=0 -> 0xFFFFFF80.
  - lbu 0x21 -> 0x00000080.
- Half store 0xBEEF to 0x32, then lh 0x32 -> 0xFFFFBEEF and word load 0x30 -> 0xBEEF0000 (lanes 0-1 untouched).
- Errors:
  - Word load at 0x06 -> misalign_err=1, rdata=0, memory unchanged.
  - Word store at DEPTH*4=0x800 -> oob_err=1, a subsequent load of 0x000 is unchanged.
  - size=11 -> misalign_err=1.
- Reset and busy:
  - Assert rst during WAIT of a store to 0x40 -> no ready pulse; load 0x40 returns the prior value.
  - req held during busy is accepted only after busy falls.
- With DATAMEM_INIT_CLEAR_EN and DEPTH=16:
  - busy stays high for 16 cycles after reset.
  - A load of any address 0x00..0x3C returns 0.
